// File: rtl/voice_sequencer.sv
// Time-multiplexed voice sequencer: one slot per voice at the start of each frame, phase accumulation per voice.
// Optional square-wave shape per voice when VOICE_SEQUENCER_SQUARE_EN is defined; otherwise every voice is a sawtooth.

`ifndef SAMPLE_WIDTH
`define SAMPLE_WIDTH 16
`endif
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

module voice_sequencer #(
    parameter int WIDTH      = `SAMPLE_WIDTH,
    parameter int N_WAVEGENS = `N_OSCILLATORS,
    parameter int FRAME_LEN  = 384
) (
    input  logic                                   sys_clk,
    input  logic                                   rst_n,
    input  logic                                   cfg_we,
    input  logic [$clog2(N_WAVEGENS+1)-1:0]        cfg_index,
    input  logic [31:0]                            cfg_freq_step,
    input  logic                                   cfg_enable,
    input  logic                                   cfg_phase_clr,
    input  logic                                   cfg_shape,
    output logic [8:0]                             clk_counter,
    output logic                                   sample_clk,
    output logic signed [WIDTH+`FIXED_POINT-1:0]   wave,
    output logic                                   enabled,
    output logic [$clog2(N_WAVEGENS+1)-1:0]        index
);

    localparam int IDX_W = $clog2(N_WAVEGENS + 1);
    localparam int CNT_W = 9;
    localparam int OUT_W = WIDTH + `FIXED_POINT;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(FRAME_LEN / 2);
    localparam logic [CNT_W-1:0] N_LIM = CNT_W'(N_WAVEGENS);

`ifdef VOICE_SEQUENCER_SQUARE_EN
    localparam logic signed [OUT_W-1:0] SQ_HI = OUT_W'({1'b0, {(WIDTH-1){1'b1}}}) << `FIXED_POINT;
    localparam logic signed [OUT_W-1:0] SQ_LO = {1'b1, {(OUT_W-1){1'b0}}};
`endif

    logic [CNT_W-1:0]        r_clk_counter;
    logic                    r_sample_clk;
    logic [IDX_W-1:0]        r_index;
    logic signed [OUT_W-1:0] r_wave;
    logic                    r_enabled;

    logic [31:0]             r_phase [N_WAVEGENS];
    logic [31:0]             r_step  [N_WAVEGENS];
    logic                    r_en    [N_WAVEGENS];
`ifdef VOICE_SEQUENCER_SQUARE_EN
    logic                    r_shape [N_WAVEGENS];
    logic                    w_sel_shape;
`endif

    logic [CNT_W-1:0]        w_cnt_next;
    logic [N_WAVEGENS-1:0]   w_wr;
    logic [N_WAVEGENS-1:0]   w_adv;
    logic [31:0]             w_sel_phase;
    logic                    w_sel_en;
    logic signed [OUT_W-1:0] w_saw;
    logic signed [OUT_W-1:0] w_sel_wave;
    logic [32:0]             w_unused;

    assign w_cnt_next = (r_clk_counter == LAST) ? '0 : r_clk_counter + CNT_W'(1);

    // A voice advances on the edge that ends its own slot; a config write to it on that edge takes priority.
    for (genvar gi = 0; gi < N_WAVEGENS; gi++) begin : g_voice
        assign w_wr[gi]  = cfg_we && (cfg_index == IDX_W'(gi));
        assign w_adv[gi] = (r_clk_counter == CNT_W'(gi));
    end

    always_ff @(posedge sys_clk) begin
        for (int v = 0; v < N_WAVEGENS; v++) begin
            if (!rst_n) begin
                r_phase[v] <= '0;
                r_step[v]  <= '0;
                r_en[v]    <= 1'b0;
`ifdef VOICE_SEQUENCER_SQUARE_EN
                r_shape[v] <= 1'b0;
`endif
            end else if (w_wr[v]) begin
                r_step[v] <= cfg_freq_step;
                r_en[v]   <= cfg_enable;
`ifdef VOICE_SEQUENCER_SQUARE_EN
                r_shape[v] <= cfg_shape;
`endif
                if (cfg_phase_clr) begin
                    r_phase[v] <= '0;
                end
            end else if (w_adv[v] && r_en[v]) begin
                r_phase[v] <= r_phase[v] + r_step[v];
            end
        end
    end

    // Select the voice whose slot starts on the coming edge, using its not-yet-advanced phase.
    always_comb begin
        w_sel_phase = '0;
        w_sel_en    = 1'b0;
`ifdef VOICE_SEQUENCER_SQUARE_EN
        w_sel_shape = 1'b0;
`endif
        for (int v = 0; v < N_WAVEGENS; v++) begin
            if (w_cnt_next == CNT_W'(v)) begin
                w_sel_phase = r_phase[v];
                w_sel_en    = r_en[v];
`ifdef VOICE_SEQUENCER_SQUARE_EN
                w_sel_shape = r_shape[v];
`endif
            end
        end
    end

    assign w_saw = OUT_W'($signed(w_sel_phase[31 -: WIDTH])) <<< `FIXED_POINT;

`ifdef VOICE_SEQUENCER_SQUARE_EN
    assign w_sel_wave = w_sel_shape ? (w_sel_phase[31] ? SQ_LO : SQ_HI) : w_saw;
`else
    assign w_sel_wave = w_saw;
`endif

    assign w_unused = {cfg_shape, w_sel_phase};

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_clk_counter <= LAST;
            r_sample_clk  <= 1'b0;
            r_index       <= IDX_W'(N_WAVEGENS);
            r_wave        <= '0;
            r_enabled     <= 1'b0;
        end else begin
            r_clk_counter <= w_cnt_next;
            r_sample_clk  <= (w_cnt_next < HALF);
            if (w_cnt_next < N_LIM) begin
                r_index   <= IDX_W'(w_cnt_next);
                r_enabled <= w_sel_en;
                r_wave    <= w_sel_en ? w_sel_wave : '0;
            end else begin
                r_index   <= IDX_W'(N_WAVEGENS);
                r_enabled <= 1'b0;
                r_wave    <= '0;
            end
        end
    end

    assign clk_counter = r_clk_counter;
    assign sample_clk  = r_sample_clk;
    assign index       = r_index;
    assign wave        = r_wave;
    assign enabled     = r_enabled;

endmodule

// File: tb/tb_voice_sequencer.sv
// Randomised scoreboard bench for voice_sequencer: a frame-level reference model predicts every cycle's outputs.

`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

module tb_voice_sequencer;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int FL    = 384;
    localparam int FP    = `FIXED_POINT;
    localparam int IDX_W = $clog2(N + 1);
    localparam int OUT_W = W + FP;

    logic                    sys_clk;
    logic                    rst_n;
    logic                    cfg_we;
    logic [IDX_W-1:0]        cfg_index;
    logic [31:0]             cfg_freq_step;
    logic                    cfg_enable;
    logic                    cfg_phase_clr;
    logic                    cfg_shape;
    logic [8:0]              clk_counter;
    logic                    sample_clk;
    logic signed [OUT_W-1:0] wave;
    logic                    enabled;
    logic [IDX_W-1:0]        index;

    voice_sequencer #(.WIDTH(W), .N_WAVEGENS(N), .FRAME_LEN(FL)) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .cfg_index     (cfg_index),
        .cfg_freq_step (cfg_freq_step),
        .cfg_enable    (cfg_enable),
        .cfg_phase_clr (cfg_phase_clr),
        .cfg_shape     (cfg_shape),
        .clk_counter   (clk_counter),
        .sample_clk    (sample_clk),
        .wave          (wave),
        .enabled       (enabled),
        .index         (index)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int     cnt;
        bit     sclk;
        int     idx;
        bit     en;
        longint wave;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Reference model state: one entry per voice plus the frame position.
    int        m_cnt = FL - 1;
    bit [31:0] m_phase [N];
    bit [31:0] m_step  [N];
    bit        m_en    [N];
    bit        m_shape [N];

    function automatic longint ref_wave(int v);
        longint one = 1;
        longint top;
`ifdef VOICE_SEQUENCER_SQUARE_EN
        if (m_shape[v])
            return m_phase[v][31] ? -(one << (W-1)) * (one << FP) : ((one << (W-1)) - 1) * (one << FP);
`endif
        top = longint'(m_phase[v] >> (32 - W));
        if (top >= (one << (W-1))) top = top - (one << W);
        return top * (one << FP);
    endfunction

    function automatic void model_edge(bit rn, bit we, int idx, bit [31:0] st, bit en, bit clr, bit shp);
        exp_t e;
        int   prev;
        if (!rn) begin
            m_cnt = FL - 1;
            for (int v = 0; v < N; v++) begin
                m_phase[v] = '0; m_step[v] = '0; m_en[v] = 1'b0; m_shape[v] = 1'b0;
            end
            e.cnt = FL - 1; e.sclk = 1'b0; e.idx = N; e.en = 1'b0; e.wave = 0;
        end else begin
            prev  = m_cnt;
            m_cnt = (m_cnt + 1) % FL;
            e.cnt  = m_cnt;
            e.sclk = (m_cnt < FL / 2);
            if (m_cnt < N) begin
                e.idx  = m_cnt;
                e.en   = m_en[m_cnt];
                e.wave = m_en[m_cnt] ? ref_wave(m_cnt) : 0;
            end else begin
                e.idx = N; e.en = 1'b0; e.wave = 0;
            end
            if (prev < N && m_en[prev] && !(we && idx == prev))
                m_phase[prev] = m_phase[prev] + m_step[prev];
            if (we && idx < N) begin
                m_step[idx]  = st;
                m_en[idx]    = en;
                m_shape[idx] = shp;
                if (clr) m_phase[idx] = '0;
            end
        end
        exp_q.push_back(e);
    endfunction

    task automatic step_cycle(input bit rn, input bit we, input int idx, input bit [31:0] st,
                              input bit en, input bit clr, input bit shp);
        @(negedge sys_clk);
        if (we)
            $display("cfg write: idx=%0d step=%h en=%0b clr=%0b shape=%0b at counter=%0d", idx, st, en, clr, shp, m_cnt);
        rst_n         = rn;
        cfg_we        = we;
        cfg_index     = IDX_W'(idx);
        cfg_freq_step = st;
        cfg_enable    = en;
        cfg_phase_clr = clr;
        cfg_shape     = shp;
        model_edge(rn, we, idx, st, en, clr, shp);
    endtask

    task automatic idle();
        step_cycle(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_cnt(input int c);
        while (m_cnt != c) idle();
    endtask

    task automatic random_frames(input int frames);
        bit [31:0] st;
        for (int i = 0; i < frames * FL; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0:       st = $urandom;
                    1:       st = 32'h1000_0000;
                    2:       st = 32'hFFFF_0000;
                    3:       st = 32'h8000_0000;
                    default: st = 32'h4000_0000;
                endcase
                step_cycle(1'b1, 1'b1, int'($urandom_range(0, 7)), st, $urandom_range(0, 3) != 0,
                           1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
            end else begin
                idle();
            end
        end
    endtask

    // Monitor: every cycle the DUT presents a slot; compare it with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (clk_counter !== 9'(e.cnt) || sample_clk !== e.sclk || index !== IDX_W'(e.idx) ||
                    enabled !== e.en || wave !== OUT_W'(e.wave)) begin
                    n_fails++;
                    $display("FAIL slot_check t=%0t: got cnt=%0d sclk=%0b idx=%0d en=%0b wave=%0d, required cnt=%0d sclk=%0b idx=%0d en=%0b wave=%0d",
                             $time, clk_counter, sample_clk, index, enabled, wave,
                             e.cnt, e.sclk, e.idx, e.en, e.wave);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_index = '0; cfg_freq_step = '0;
        cfg_enable = 1'b0; cfg_phase_clr = 1'b0; cfg_shape = 1'b0;

        repeat (3) step_cycle(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Voice 1 ramps by 0x1000 per frame, others silent.
        wait_cnt(N);
        step_cycle(1'b1, 1'b1, 1, 32'h1000_0000, 1'b1, 1'b1, 1'b0);
        repeat (6 * FL) idle();

        // Voice 2 running, then cleared on the very edge that would advance it.
        wait_cnt(N);
        step_cycle(1'b1, 1'b1, 2, 32'h3000_0000, 1'b1, 1'b1, 1'b0);
        repeat (2 * FL) idle();
        wait_cnt(2);
        step_cycle(1'b1, 1'b1, 2, 32'h3000_0000, 1'b1, 1'b1, 1'b0);
        wait_cnt(N);
        step_cycle(1'b1, 1'b1, 7, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        repeat (2 * FL) idle();

        // Square/sawtooth extremes: 0x8000_0000 and 0x4000_0000 phases.
        wait_cnt(N);
        step_cycle(1'b1, 1'b1, 0, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
        step_cycle(1'b1, 1'b1, 3, 32'h4000_0000, 1'b1, 1'b1, 1'b0);
        repeat (3 * FL) idle();

        random_frames(20);

        // Mid-frame reset: state discarded, voices silent afterwards.
        wait_cnt(100);
        step_cycle(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2 * FL) idle();

        random_frames(5);

        repeat (3) @(posedge sys_clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain_check: got %0d pending predictions, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
